muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide engine for MIPS MULT/MULTU/DIV/DIVU. Sits in EX, directly upstream of the HI/LO register file. Produces the 64-bit result as hi/lo write data plus a 2-bit write enable. Raises a stall request to the pipeline while an operation is in flight.

---
 rtl/muldiv_unit.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle integer multiply/divide engine for MIPS MULT/MULTU/DIV/DIVU.
// It sits in EX and feeds the HI/LO register file. Multiplies complete MUL_LAT
// cycles after the start cycle. Divides use restoring division on operand
// magnitudes and complete 33 cycles after the start cycle.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   reset      in   asynchronous active-high reset
//   start      in   issue pulse from EX, sampled only in IDLE
//   op         in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      in   rs operand (multiplicand / dividend)
//   src_b      in   rt operand (multiplier / divisor)
//   flush      in   cancels an in-flight op, or masks the write in DONE
//   busy       out  operation in flight (MUL or DIV state)
//   stall_req  out  pipeline must hold EX
//   done       out  one-cycle result-valid pulse
//   hilo_wen   out  {hi_en, lo_en}
//   hi_wdata   out  HI write data (product[63:32] / remainder)
//   lo_wdata   out  LO write data (product[31:0] / quotient)
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        stall_req,
   output logic        done,
   output logic [1:0]  hilo_wen,
   output logic [31:0] hi_wdata,
   output logic [31:0] lo_wdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Counter value of the last MUL-state cycle (MUL state lasts MUL_LAT-1 cycles).
   localparam logic [4:0] MUL_LAST = (MUL_LAT > 1) ? 5'(MUL_LAT - 2) : 5'd0;

   state_t      state_r;
   logic [4:0]  cnt_r;
   logic [63:0] prod_r;
   logic [31:0] a_r;        // original dividend, returned as HI on divide-by-zero
   logic [31:0] dvs_r;      // divisor magnitude
   logic [31:0] rem_r;      // partial remainder
   logic [31:0] quo_r;      // dividend bits shift out, quotient bits shift in
   logic        neg_q_r;
   logic        neg_r_r;
   logic        dvz_r;
   logic        done_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   logic        sign_s;
   logic [63:0] ext_a_s;
   logic [63:0] ext_b_s;
   logic [63:0] product_s;
   logic [31:0] mag_a_s;
   logic [31:0] mag_b_s;
   logic        accept_s;
   logic [32:0] shift_s;
   logic [32:0] trial_s;
   logic        qbit_s;
   logic [31:0] rem_nxt_s;
   logic [31:0] quo_nxt_s;
   logic [31:0] div_hi_s;
   logic [31:0] div_lo_s;
   logic [1:0]  hilo_wen_s;

   // Operand conditioning: signed ops are op[0]==0 (MULT, DIV).
   always_comb begin
      sign_s    = ~op[0];
      ext_a_s   = {{32{sign_s & src_a[31]}}, src_a};
      ext_b_s   = {{32{sign_s & src_b[31]}}, src_b};
      // Low 64 bits of the sign-extended product are correct for both signednesses.
      product_s = ext_a_s * ext_b_s;
      mag_a_s   = (sign_s & src_a[31]) ? (32'd0 - src_a) : src_a;
      mag_b_s   = (sign_s & src_b[31]) ? (32'd0 - src_b) : src_b;
      accept_s  = (state_r == ST_IDLE) & start & ~flush;
   end

   // One restoring-division step plus sign fix-up of the final result.
   always_comb begin
      shift_s   = {rem_r, quo_r[31]};
      trial_s   = shift_s - {1'b0, dvs_r};
      qbit_s    = ~trial_s[32];
      rem_nxt_s = qbit_s ? trial_s[31:0] : shift_s[31:0];
      quo_nxt_s = {quo_r[30:0], qbit_s};
      div_hi_s  = 32'd0;
      div_lo_s  = 32'd0;
      if (dvz_r) begin
         div_hi_s = a_r;
         div_lo_s = 32'hFFFF_FFFF;
      end else begin
         // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000 negates to itself.
         div_lo_s = neg_q_r ? (32'd0 - quo_nxt_s) : quo_nxt_s;
         div_hi_s = neg_r_r ? (32'd0 - rem_nxt_s) : rem_nxt_s;
      end
   end

   // Main control FSM with registered result and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 5'd0;
         prod_r  <= 64'd0;
         a_r     <= 32'd0;
         dvs_r   <= 32'd0;
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         dvz_r   <= 1'b0;
         done_r  <= 1'b0;
         hi_r    <= 32'd0;
         lo_r    <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  a_r     <= src_a;
                  prod_r  <= product_s;
                  dvs_r   <= mag_b_s;
                  quo_r   <= mag_a_s;
                  rem_r   <= 32'd0;
                  neg_q_r <= sign_s & (src_a[31] ^ src_b[31]);
                  neg_r_r <= sign_s & src_a[31];
                  dvz_r   <= (src_b == 32'd0);
                  cnt_r   <= 5'd0;
                  if (op[1]) begin
                     state_r <= ST_DIV;
                  end else if (MUL_LAT == 1) begin
                     // Single-cycle latency: the start edge itself writes the result.
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     hi_r    <= product_s[63:32];
                     lo_r    <= product_s[31:0];
                  end else begin
                     state_r <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               if (flush) begin
                  state_r <= ST_IDLE;
               end else if (cnt_r == MUL_LAST) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  hi_r    <= prod_r[63:32];
                  lo_r    <= prod_r[31:0];
               end else begin
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            ST_DIV: begin
               if (flush) begin
                  state_r <= ST_IDLE;
               end else begin
                  rem_r <= rem_nxt_s;
                  quo_r <= quo_nxt_s;
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == 5'd31) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                     hi_r    <= div_hi_s;
                     lo_r    <= div_lo_s;
                  end
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Write enable is masked combinationally by a flush in the DONE cycle.
   always_comb begin
      hilo_wen_s = 2'b00;
      if (done_r & ~flush) begin
         hilo_wen_s = 2'b11;
      end else begin
         hilo_wen_s = 2'b00;
      end
   end

   assign busy      = (state_r == ST_MUL) | (state_r == ST_DIV);
   assign stall_req = busy | accept_s;
   assign done      = done_r;
   assign hilo_wen  = hilo_wen_s;
   assign hi_wdata  = hi_r;
   assign lo_wdata  = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   localparam int MUL_LAT = 2;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        stall_req;
   logic        done;
   logic [1:0]  hilo_wen;
   logic [31:0] hi_wdata;
   logic [31:0] lo_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   muldiv_unit #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush),
      .busy(busy), .stall_req(stall_req), .done(done),
      .hilo_wen(hilo_wen), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on the architectural rules, returns {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: begin q = sa * sb; res = q; end
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
            else begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue an op in the current cycle and check every cycle through the one after DONE.
   task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit scramble, input bit flush_done, input bit start_done);
      int lat;
      lat = o[1] ? 33 : MUL_LAT;
      start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
      #1;
      chk({tag, "_stall_T"}, 64'(stall_req), 64'd1);
      chk({tag, "_done_T"}, 64'(done), 64'd0);
      for (int k = 1; k < lat; k++) begin
         step();
         start = scramble && (k == 5);
         if (scramble) begin
            src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
         end
         #1;
         chk({tag, "_busy"}, 64'(busy), 64'd1);
         chk({tag, "_stall"}, 64'(stall_req), 64'd1);
         chk({tag, "_early_done"}, 64'(done), 64'd0);
         chk({tag, "_early_wen"}, 64'(hilo_wen), 64'd0);
      end
      step();
      start = start_done; flush = flush_done;
      if (start_done) begin
         op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
      end
      #1;
      chk({tag, "_done"}, 64'(done), 64'd1);
      chk({tag, "_wen"}, 64'(hilo_wen), flush_done ? 64'd0 : 64'd3);
      chk({tag, "_stall_done"}, 64'(stall_req), 64'd0);
      chk({tag, "_hilo"}, {hi_wdata, lo_wdata}, exp);
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      chk({tag, "_after_done"}, 64'(done), 64'd0);
      chk({tag, "_after_busy"}, 64'(busy), 64'd0);
      chk({tag, "_after_wen"}, 64'(hilo_wen), 64'd0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
      #3;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wen", 64'(hilo_wen), 64'd0);
      chk("rst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      step(); step();
      reset = 1'b0;
      step();

      // Directed: multiplies
      issue("mult", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0, 1'b0);
      issue("multu", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, 1'b0);
      // Directed: divides and corner cases
      issue("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
      issue("divu", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 1'b0, 1'b0, 1'b0);
      issue("divu_z", 2'b11, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
      issue("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b0);
      issue("div_z", 2'b10, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
      // Start ignored mid-DIV and during DONE
      issue("div_ign", 2'b10, 32'd1000, 32'hFFFF_FFF9, 64'h0000_0006_FFFF_FF72, 1'b1, 1'b0, 1'b1);
      // Flush coincident with DONE masks the write
      issue("flush_done", 2'b00, 32'd5, 32'd7, 64'd35, 1'b0, 1'b1, 1'b0);

      // start & flush in the same cycle is ignored
      start = 1'b1; flush = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd3;
      #1;
      chk("sf_stall", 64'(stall_req), 64'd0);
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      chk("sf_busy", 64'(busy), 64'd0);

      // Flush mid-DIV at T+10, new MULT accepted at T+11
      start = 1'b1; op = 2'b10; src_a = 32'd77; src_b = 32'd5;
      for (int k = 1; k <= 9; k++) begin
         step();
         start = 1'b0;
      end
      step();
      flush = 1'b1;
      #1;
      chk("fl_busy_T10", 64'(busy), 64'd1);
      chk("fl_wen_T10", 64'(hilo_wen), 64'd0);
      step();
      flush = 1'b0;
      #1;
      chk("fl_busy_T11", 64'(busy), 64'd0);
      chk("fl_done_T11", 64'(done), 64'd0);
      chk("fl_wen_T11", 64'(hilo_wen), 64'd0);
      issue("fl_mult", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);

      // Reset asserted mid-DIV
      start = 1'b1; op = 2'b11; src_a = 32'd12345; src_b = 32'd17;
      for (int k = 1; k <= 7; k++) begin
         step();
         start = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_stall", 64'(stall_req), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_wen", 64'(hilo_wen), 64'd0);
      chk("mrst_hilo", {hi_wdata, lo_wdata}, 64'd0);
      step();
      reset = 1'b0;
      step();
      issue("post_rst", 2'b01, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);

      // Randomized ops against the reference model, issued back-to-back
      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 4))
            0: rb = 32'd0;
            1: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: rb = 32'($urandom_range(0, 7)) - 32'd3;
            default: ;
         endcase
         issue("rand", ro, ra, rb, model(ro, ra, rb), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
